// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: ADC acquisition sequencer with circular pre-trigger capture into a RAM
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   rate_sel          sample period = 2<<rate_sel clocks, latched on arm
//   trig_level        unsigned trigger threshold, latched on arm
//   trig_edge         0 = rising, 1 = falling, latched on arm
//   arm               start a capture (only from IDLE/DONE)
//   force_trig        trigger at the next write while waiting for a trigger
//   addata            ADC sample bus
//   adclk             ADC clock
//   wr_en/addr/data   capture RAM write port, one strobe per sample
//   busy, done        capture in progress / capture complete
//   trig_addr         RAM address of the trigger sample
module scope_capture_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int PRE_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rate_sel,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [7:0]        addata,
    output logic              adclk,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] POST_LEN = ADDR_W'(DEPTH - PRE_DEPTH - 1);
    localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, WAIT = 3'd2, POST = 3'd3, DONE = 3'd4;
    logic [2:0]        state, rate;
    logic [7:0]        level, cnt, cur, prev, last_cnt;
    logic              edge_f, pend, strobe, hit;
    logic [ADDR_W-1:0] pre_cnt, post_cnt;
    always_comb begin
        last_cnt = 8'((9'd2 << rate) - 9'd1);
        busy     = state == PRE || state == WAIT || state == POST;
        done     = state == DONE;
        adclk    = busy && cnt <= (last_cnt >> 1);
        strobe   = busy && cnt == last_cnt;
        // prev is always valid here: PRE_DEPTH >= 1 keeps the first sample out of WAIT
        hit      = state == WAIT && wr_en &&
                   (pend || (edge_f ? (prev > level && cur <= level) : (prev < level && cur >= level)));
    end
    assign wr_data = cur;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rate      <= '0;
            level     <= '0;
            edge_f    <= 1'b0;
            cnt       <= '0;
            cur       <= '0;
            prev      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            trig_addr <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            pend      <= 1'b0;
        end else if (!busy) begin
            wr_en <= 1'b0;
            if (arm) begin
                state   <= PRE;
                rate    <= rate_sel;
                level   <= trig_level;
                edge_f  <= trig_edge;
                cnt     <= '0;
                wr_addr <= '0;
                pre_cnt <= '0;
                pend    <= 1'b0;
            end
        end else begin
            cnt   <= strobe ? 8'd0 : cnt + 8'd1;
            wr_en <= strobe;
            if (strobe) begin
                cur  <= addata;
                prev <= cur;
            end
            if (state == WAIT && force_trig)
                pend <= 1'b1;
            if (wr_en) begin
                wr_addr <= wr_addr + ADDR_W'(1);
                if (state == PRE) begin
                    pre_cnt <= pre_cnt + ADDR_W'(1);
                    if (pre_cnt == PRE_LAST)
                        state <= WAIT;
                end
                if (hit) begin
                    trig_addr <= wr_addr;
                    post_cnt  <= POST_LEN;
                    pend      <= 1'b0;
                    state     <= (POST_LEN == '0) ? DONE : POST;
                end
                if (state == POST) begin
                    post_cnt <= post_cnt - ADDR_W'(1);
                    if (post_cnt == ADDR_W'(1))
                        state <= DONE;
                end
            end
        end
    end
endmodule
